// File: rtl/counter_ctrl_seq.sv
// counter_ctrl_seq: control sequencer driving an 8-bit programmable counter's strobes.
// Optional feature macro: CTRL_STEP_STATS_EN (adds step_total output).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   run               level, free-run stepping while high
//   burst_start       pulse, start a burst of burst_len steps
//   burst_len         burst step count, sampled on accepted burst_start
//   div               prescaler divisor, one step every div+1 clocks
//   dir_up            direction, 1=up 0=down
//   ld_valid/ld_data  load request and value; ld_ready accepts it
//   cnt_en/cnt_load   registered one-cycle step/load strobes
//   cnt_up/cnt_p      registered direction and parallel-load value
//   busy              sequencer not idle
//   burst_done        pulse together with the final burst step
//   step_total        saturating step count, cleared by load (macro only)
module counter_ctrl_seq #(
    parameter int DIV_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [DIV_W-1:0]   div,
    input  logic               dir_up,
    input  logic               ld_valid,
    input  logic [7:0]         ld_data,
    output logic               ld_ready,
    output logic               cnt_en,
    output logic               cnt_load,
    output logic               cnt_up,
    output logic [7:0]         cnt_p,
    output logic               busy,
    output logic               burst_done
`ifdef CTRL_STEP_STATS_EN
    ,
    output logic [15:0]        step_total
`endif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] BURST = 2'd2;
    localparam logic [1:0] LOAD  = 2'd3;

    logic [1:0]         state;
    logic [DIV_W-1:0]   pre_q;
    logic [BURST_W-1:0] rem_q;
    logic               tick;
    logic               accept;
    logic               step;
    logic               burst_ok;

    assign ld_ready = (state == IDLE || state == RUN) && !rst;
    assign accept   = ld_valid && ld_ready;
    assign tick     = (state == RUN || state == BURST) && pre_q == '0;
    // a load accepted on a tick cycle swallows that step
    assign step     = tick && !accept;
    assign burst_ok = burst_start && burst_len != '0;
    assign busy     = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pre_q      <= '0;
            rem_q      <= '0;
            cnt_en     <= 1'b0;
            cnt_load   <= 1'b0;
            cnt_up     <= 1'b0;
            cnt_p      <= 8'h00;
            burst_done <= 1'b0;
        end else begin
            cnt_en     <= step;
            cnt_load   <= accept;
            burst_done <= step && state == BURST && rem_q == BURST_W'(1);
            cnt_p      <= accept ? ld_data : cnt_p;
            cnt_up     <= step ? dir_up : cnt_up;
            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        state <= LOAD;
                    end else if (burst_ok) begin
                        state <= BURST;
                        rem_q <= burst_len;
                        pre_q <= div;
                    end else if (run) begin
                        state <= RUN;
                        pre_q <= (state == IDLE || tick) ? div : pre_q - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                BURST: begin
                    pre_q <= tick ? div : pre_q - 1'b1;
                    rem_q <= tick ? rem_q - 1'b1 : rem_q;
                    state <= (tick && rem_q == BURST_W'(1)) ? (run ? RUN : IDLE) : BURST;
                end
                LOAD: begin
                    state <= run ? RUN : IDLE;
                    pre_q <= div;
                end
            endcase
        end
    end

`ifdef CTRL_STEP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            step_total <= '0;
        else if (cnt_load)
            step_total <= '0;
        else if (cnt_en && step_total != 16'hFFFF)
            step_total <= step_total + 16'd1;
    end
`endif
endmodule

// File: tb/tb_counter_ctrl_seq.sv
// tb_counter_ctrl_seq: self-checking bench for counter_ctrl_seq.
module tb_counter_ctrl_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       burst_start = 1'b0;
    logic [7:0] burst_len = 8'd0;
    logic [7:0] div = 8'd0;
    logic       dir_up = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = 8'd0;
    logic       ld_ready, cnt_en, cnt_load, cnt_up, busy, burst_done;
    logic [7:0] cnt_p;
`ifdef CTRL_STEP_STATS_EN
    logic [15:0] step_total;
`endif

    int checks = 0;
    int errors = 0;

    counter_ctrl_seq dut (
        .clk(clk), .rst(rst), .run(run), .burst_start(burst_start),
        .burst_len(burst_len), .div(div), .dir_up(dir_up),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_up(cnt_up),
        .cnt_p(cnt_p), .busy(busy), .burst_done(burst_done)
`ifdef CTRL_STEP_STATS_EN
        , .step_total(step_total)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: tracks what activity is in progress, how many
    // clocks remain until the next step, and how many burst steps are left.
    logic        m_run, m_burst, m_load;
    int          m_cd, m_left;
    logic        e_en, e_load, e_up, e_done;
    logic [7:0]  e_p;
    logic [15:0] e_tot;
    logic        e_busy, e_rdy;
    assign e_busy = m_run || m_burst || m_load;
    assign e_rdy  = !m_load && !m_burst && !rst;

    always @(posedge clk or posedge rst) begin
        logic acc, tk, stp;
        if (rst) begin
            m_run = 0; m_burst = 0; m_load = 0; m_cd = 0; m_left = 0;
            e_en = 0; e_load = 0; e_up = 0; e_done = 0; e_p = 0; e_tot = 0;
        end else begin
            acc = ld_valid && !m_load && !m_burst;
            tk  = (m_run || m_burst) && m_cd == 0;
            stp = tk && !acc;
            e_tot  = e_load ? 16'd0 : (e_en && e_tot != 16'hFFFF) ? e_tot + 16'd1 : e_tot;
            e_done = stp && m_burst && m_left == 1;
            e_en   = stp;
            e_load = acc;
            if (acc) e_p = ld_data;
            if (stp) e_up = dir_up;
            if (m_load) begin
                m_load = 0; m_run = run; m_cd = int'(div);
            end else if (acc) begin
                m_load = 1; m_run = 0;
            end else if (m_burst) begin
                if (tk) begin
                    m_left = m_left - 1;
                    m_cd = int'(div);
                    if (m_left == 0) begin m_burst = 0; m_run = run; end
                end else m_cd = m_cd - 1;
            end else if (burst_start && burst_len != 0) begin
                m_burst = 1; m_run = 0; m_left = int'(burst_len); m_cd = int'(div);
            end else if (m_run) begin
                m_run = run;
                m_cd = tk ? int'(div) : m_cd - 1;
            end else if (run) begin
                m_run = 1; m_cd = int'(div);
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic mcmp();
        chk("m_en", 16'(cnt_en), 16'(e_en));
        chk("m_load", 16'(cnt_load), 16'(e_load));
        chk("m_up", 16'(cnt_up), 16'(e_up));
        chk("m_p", 16'(cnt_p), 16'(e_p));
        chk("m_busy", 16'(busy), 16'(e_busy));
        chk("m_done", 16'(burst_done), 16'(e_done));
        chk("m_rdy", 16'(ld_ready), 16'(e_rdy));
`ifdef CTRL_STEP_STATS_EN
        chk("m_total", step_total, e_tot);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        mcmp();
    endtask

    typedef struct {
        logic run, bs; logic [7:0] len, dv; logic lv; logic [7:0] ld;
        logic en, load, bsy, done, rdy; logic [7:0] p;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int n, first, last, badsp, badup, loads;
        tbl[0] = '{1'b0, 1'b1, 8'd2, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 8'd2, 8'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 8'd2, 8'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 8'd2, 8'd0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
        tbl[4] = '{1'b0, 1'b0, 8'd2, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
        tbl[5] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
        tbl[6] = '{1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C};
        tbl[7] = '{1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C};
        tbl[8] = '{1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C};
        tbl[9] = '{1'b0, 1'b0, 8'd0, 8'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};

        // reset with busy-looking inputs: everything must stay quiet, ld_ready gated
        run = 1; ld_valid = 1; ld_data = 8'hFF; div = 8'd0;
        cyc(); cyc();
        chk("rst_en", 16'(cnt_en), 16'd0);
        chk("rst_load", 16'(cnt_load), 16'd0);
        chk("rst_p", 16'(cnt_p), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_rdy", 16'(ld_ready), 16'd0);
        run = 0; ld_valid = 0; ld_data = 0; dir_up = 1;
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            run = tbl[i].run; burst_start = tbl[i].bs; burst_len = tbl[i].len;
            div = tbl[i].dv; ld_valid = tbl[i].lv; ld_data = tbl[i].ld;
            cyc();
            chk($sformatf("tbl%0d_en", i), 16'(cnt_en), 16'(tbl[i].en));
            chk($sformatf("tbl%0d_load", i), 16'(cnt_load), 16'(tbl[i].load));
            chk($sformatf("tbl%0d_busy", i), 16'(busy), 16'(tbl[i].bsy));
            chk($sformatf("tbl%0d_done", i), 16'(burst_done), 16'(tbl[i].done));
            chk($sformatf("tbl%0d_rdy", i), 16'(ld_ready), 16'(tbl[i].rdy));
            chk($sformatf("tbl%0d_p", i), 16'(cnt_p), 16'(tbl[i].p));
        end
        burst_start = 0; ld_valid = 0; run = 0;

        // free-run, div=3: pulses every 4 clocks, first 4 edges after run is sampled
        div = 3; dir_up = 1; n = 0; first = -1; last = -1; badsp = 0; badup = 0;
        for (int k = 0; k < 47; k++) begin
            run = k < 40;
            cyc();
            if (cnt_en) begin
                if (first < 0) first = k;
                if (last >= 0 && k - last != 4) badsp++;
                if (!cnt_up) badup++;
                last = k; n++;
            end
        end
        chk("run_first", 16'(first), 16'd4);
        chk("run_count", 16'(n), 16'd10);
        chk("run_spacing", 16'(badsp), 16'd0);
        chk("run_up", 16'(badup), 16'd0);

        // burst of 5 at div=0, with ignored load requests during it
        div = 0; burst_len = 5; burst_start = 1; n = 0; loads = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            burst_start = 0;
            ld_valid = k < 3; ld_data = 8'h11;
            if (cnt_en) n++;
            if (cnt_load) loads++;
            chk($sformatf("bst%0d_en", k), 16'(cnt_en), 16'(k >= 1 && k <= 5));
            chk($sformatf("bst%0d_done", k), 16'(burst_done), 16'(k == 5));
            if (k < 5) chk($sformatf("bst%0d_rdy", k), 16'(ld_ready), 16'd0);
            if (k == 5) chk("bst_busy_drop", 16'(busy), 16'd0);
        end
        chk("bst_count", 16'(n), 16'd5);
        chk("bst_noload", 16'(loads), 16'd0);

        // burst_start during a burst is ignored
        div = 1; burst_len = 3; burst_start = 1; n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            burst_start = k == 2; burst_len = k == 2 ? 8'd7 : 8'd3;
            if (cnt_en) n++;
        end
        chk("bst_ignore_count", 16'(n), 16'd3);

        // load on a tick cycle in RUN drops the step
        div = 2; run = 1;
        for (int k = 0; k < 9; k++) begin
            ld_valid = k == 3; ld_data = 8'hA5;
            run = k < 8;
            cyc();
            if (k == 3) begin
                chk("col_en_dropped", 16'(cnt_en), 16'd0);
                chk("col_load", 16'(cnt_load), 16'd1);
                chk("col_p", 16'(cnt_p), 16'h00A5);
            end
            if (k >= 4 && k <= 6) chk($sformatf("col%0d_en", k), 16'(cnt_en), 16'd0);
            if (k == 4) chk("col_load_once", 16'(cnt_load), 16'd0);
            if (k == 7) chk("col_next_step", 16'(cnt_en), 16'd1);
        end
        ld_valid = 0; run = 0;
        cyc();

        // reset in the middle of a long burst
        div = 0; burst_len = 200; burst_start = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            burst_start = 0;
        end
        chk("mid_en_before", 16'(cnt_en), 16'd1);
        #2 rst = 1;
        #1;
        chk("mid_en", 16'(cnt_en), 16'd0);
        chk("mid_busy", 16'(busy), 16'd0);
        chk("mid_rdy", 16'(ld_ready), 16'd0);
        chk("mid_p", 16'(cnt_p), 16'd0);
        cyc();
        rst = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("post%0d_en", k), 16'(cnt_en), 16'd0);
            chk($sformatf("post%0d_busy", k), 16'(busy), 16'd0);
        end

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            run = $urandom_range(0, 3) != 0;
            burst_start = $urandom_range(0, 9) == 0;
            burst_len = 8'($urandom_range(0, 6));
            div = 8'($urandom_range(0, 3));
            dir_up = 1'($urandom_range(0, 1));
            ld_valid = $urandom_range(0, 7) == 0;
            ld_data = 8'($urandom);
            cyc();
        end
        run = 0; burst_start = 0; ld_valid = 0;
        for (int k = 0; k < 12; k++) cyc();

`ifdef CTRL_STEP_STATS_EN
        div = 0; run = 1;
        for (int k = 0; k < 70000; k++) cyc();
        run = 0;
        for (int k = 0; k < 3; k++) cyc();
        chk("stat_sat", step_total, 16'hFFFF);
        ld_valid = 1; ld_data = 8'h5A;
        cyc();
        ld_valid = 0;
        cyc(); cyc();
        chk("stat_clear", step_total, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
